// File: rtl/dmem_mmio.sv
// dmem_mmio -- data-side memory responder for the single-cycle MIPS core.
// Loads are combinational and right-justified with zero fill. Stores commit at
// the rising edge, and byte/halfword lanes are steered into place.
// Optional feature macro: DMEM_MMIO_EN. When it is defined, addr[31]=1 selects
// an MMIO window with four registers: LED, COUNT, CMP and STATUS. It also adds
// a compare-match timer driving irq. When it is undefined, every address maps
// to RAM and led/irq are tied low.
module dmem_mmio #(
  parameter int DEPTH = 1024,
  parameter int LEDW  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            MemWrite,
  input  logic [31:0]     addr,
  input  logic [31:0]     writedata,
  input  logic [1:0]      memOp,
  output logic [31:0]     readdata,
  output logic [LEDW-1:0] led,
  output logic            irq
);

  localparam int AW = $clog2(DEPTH);

  // True when the access size needs stricter alignment than addr provides.
  function automatic logic misaligned(input logic [1:0] op, input logic [1:0] a);
    case (op)
      2'b01:   misaligned = a[0];
      2'b10:   misaligned = 1'b0;
      default: misaligned = (a != 2'b00);
    endcase
  endfunction

  // Byte-lane enables for a store of the given size at the given offset.
  function automatic logic [3:0] lane_enable(input logic [1:0] op, input logic [1:0] a);
    case (op)
      2'b01:   lane_enable = a[1] ? 4'b1100 : 4'b0011;
      2'b10:   lane_enable = 4'b0001 << a;
      default: lane_enable = 4'b1111;
    endcase
  endfunction

  // Replicate right-justified store data so every candidate lane carries it.
  function automatic logic [31:0] lane_data(input logic [1:0] op, input logic [31:0] wd);
    case (op)
      2'b01:   lane_data = {2{wd[15:0]}};
      2'b10:   lane_data = {4{wd[7:0]}};
      default: lane_data = wd;
    endcase
  endfunction

  // Pull the addressed lanes down to the LSBs and zero-fill the rest.
  function automatic logic [31:0] lane_extract(input logic [1:0] op, input logic [1:0] a,
                                               input logic [31:0] word);
    case (op)
      2'b01:   lane_extract = a[1] ? {16'h0000, word[31:16]} : {16'h0000, word[15:0]};
      2'b10:   lane_extract = {24'h000000, word[{a, 3'b000} +: 8]};
      default: lane_extract = word;
    endcase
  endfunction

  logic [31:0]   mem_r [DEPTH];
  logic [AW-1:0] word_idx_s;
  logic          misalign_s;
  logic          ram_sel_s;
  logic          ram_we_s;
  logic [3:0]    be_s;
  logic [31:0]   wlanes_s;
  logic [31:0]   ram_word_s;
  logic [31:0]   mmio_rdata_s;
  logic          unused_addr_s;

  // Upper address bits only ever wrap the RAM index or alias the MMIO window.
  assign unused_addr_s = &{1'b0, addr[31:AW+2]};

  assign word_idx_s = addr[AW+1:2];
  assign misalign_s = misaligned(memOp, addr[1:0]);
  assign be_s       = lane_enable(memOp, addr[1:0]);
  assign wlanes_s   = lane_data(memOp, writedata);
  assign ram_word_s = mem_r[word_idx_s];
  // A store that coincides with reset is dropped.
  assign ram_we_s   = MemWrite & ram_sel_s & ~misalign_s & ~rst;

  // RAM store: commit only the enabled byte lanes at the rising edge.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ram_we_s && be_s[i]) begin
        mem_r[word_idx_s][8*i +: 8] <= wlanes_s[8*i +: 8];
      end
    end
  end

`ifdef DMEM_MMIO_EN
  logic [LEDW-1:0] led_r;
  logic [31:0]     count_r;
  logic [31:0]     cmp_r;
  logic [1:0]      status_r;
  logic            is_word_s;
  logic            mmio_sel_s;
  logic            mmio_ok_s;
  logic            mmio_wr_s;
  logic            wr_led_s;
  logic            wr_cmp_s;
  logic            wr_status_s;
  logic            match_s;
  logic            err_s;

  assign ram_sel_s   = ~addr[31];
  assign mmio_sel_s  = addr[31];
  assign is_word_s   = (memOp[1] == memOp[0]);
  assign mmio_ok_s   = mmio_sel_s & is_word_s & ~misalign_s;
  assign mmio_wr_s   = MemWrite & mmio_ok_s;
  assign wr_led_s    = mmio_wr_s & (addr[3:2] == 2'b00);
  assign wr_cmp_s    = mmio_wr_s & (addr[3:2] == 2'b10);
  assign wr_status_s = mmio_wr_s & (addr[3:2] == 2'b11);
  // A CMP write restarts the timer and takes priority over a coincident match.
  assign match_s     = (cmp_r != 32'h0) & (count_r == cmp_r) & ~wr_cmp_s;
  assign err_s       = misalign_s | (mmio_sel_s & ~is_word_s);

  // MMIO registers: LED latch, compare-match timer and W1C status (set beats clear).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_r    <= '0;
      count_r  <= 32'h0;
      cmp_r    <= 32'h0;
      status_r <= 2'b00;
    end else begin
      if (wr_led_s) begin
        led_r <= writedata[LEDW-1:0];
      end
      if (wr_cmp_s) begin
        cmp_r   <= writedata;
        count_r <= 32'h0;
      end else if (match_s) begin
        count_r <= 32'h0;
      end else begin
        count_r <= count_r + 32'd1;
      end
      status_r[0] <= match_s | (status_r[0] & ~(wr_status_s & writedata[0]));
      status_r[1] <= err_s   | (status_r[1] & ~(wr_status_s & writedata[1]));
    end
  end

  // MMIO read mux: only well-formed word accesses return register contents.
  always_comb begin
    mmio_rdata_s = 32'h0;
    if (mmio_ok_s) begin
      case (addr[3:2])
        2'b00:   mmio_rdata_s = 32'(led_r);
        2'b01:   mmio_rdata_s = count_r;
        2'b10:   mmio_rdata_s = cmp_r;
        2'b11:   mmio_rdata_s = {30'h0, status_r};
        default: mmio_rdata_s = 32'h0;
      endcase
    end else begin
      mmio_rdata_s = 32'h0;
    end
  end

  assign led = led_r;
  assign irq = status_r[0];
`else
  assign ram_sel_s    = 1'b1;
  assign mmio_rdata_s = 32'h0;
  assign led          = '0;
  assign irq          = 1'b0;
`endif

  // Load path: misaligned accesses read zero, otherwise steer from RAM or MMIO.
  always_comb begin
    readdata = 32'h0;
    if (misalign_s) begin
      readdata = 32'h0;
    end else if (ram_sel_s) begin
      readdata = lane_extract(memOp, addr[1:0], ram_word_s);
    end else begin
      readdata = mmio_rdata_s;
    end
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// tb_dmem_mmio -- self-checking bench for dmem_mmio.
// A RAM lane-steering vector table is applied in a loop. Hand-written sequences
// then cover the MMIO registers, the timer corners and asynchronous reset.
// Readdata expectations pass through a scoreboard queue.
module tb_dmem_mmio;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemWrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [1:0]  memOp;
  logic [31:0] readdata;
  logic [15:0] led;
  logic        irq;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [1:0]  op;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [20];

  dmem_mmio dut (
    .clk       (clk),
    .rst       (rst),
    .MemWrite  (MemWrite),
    .addr      (addr),
    .writedata (writedata),
    .memOp     (memOp),
    .readdata  (readdata),
    .led       (led),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Drive one bus cycle and queue the readdata expectation for it.
  task automatic apply(input string nm, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [1:0] op,
                       input logic chk, input logic [31:0] exp);
    MemWrite = we; addr = a; writedata = wd; memOp = op;
    if (chk) begin
      exp_q.push_back(exp);
      name_q.push_back(nm);
    end
  endtask

  // Mid-cycle: pop queued expectations and compare against readdata.
  task automatic settle();
    @(negedge clk);
    while (exp_q.size() > 0) begin
      check(name_q.pop_front(), readdata, exp_q.pop_front());
    end
  endtask

  // Cross the next rising edge and return the bus to an aligned idle word read.
  task automatic tick();
    @(posedge clk);
    #1;
    MemWrite = 1'b0; addr = 32'h0; writedata = 32'h0; memOp = 2'b00;
  endtask

  task automatic cycle(input string nm, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [1:0] op,
                       input logic chk, input logic [31:0] exp);
    apply(nm, we, a, wd, op, chk, exp);
    settle();
    tick();
  endtask

  // Expected COUNT value k cycles after CMP=4 is written in the timer sequence.
  function automatic logic [31:0] exp_count(input int k);
    if (k <= 5)       exp_count = 32'(k - 1);
    else if (k <= 10) exp_count = 32'(k - 6);
    else if (k <= 15) exp_count = 32'(k - 11);
    else if (k <= 20) exp_count = 32'(k - 16);
    else              exp_count = 32'h0;
  endfunction

  initial begin
    // we, addr, wdata, op, check, expected readdata
    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 2'b00, 1'b0, 32'h0000_0000};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         2'b10, 1'b1, 32'h0000_00EF};
    vecs[2]  = '{1'b0, 32'h0000_0011, 32'h0,         2'b10, 1'b1, 32'h0000_00BE};
    vecs[3]  = '{1'b0, 32'h0000_0012, 32'h0,         2'b10, 1'b1, 32'h0000_00AD};
    vecs[4]  = '{1'b0, 32'h0000_0013, 32'h0,         2'b10, 1'b1, 32'h0000_00DE};
    vecs[5]  = '{1'b0, 32'h0000_0012, 32'h0,         2'b01, 1'b1, 32'h0000_DEAD};
    vecs[6]  = '{1'b0, 32'h0000_0010, 32'h0,         2'b01, 1'b1, 32'h0000_BEEF};
    vecs[7]  = '{1'b1, 32'h0000_0011, 32'hFFFF_FF55, 2'b10, 1'b1, 32'h0000_00BE};
    vecs[8]  = '{1'b0, 32'h0000_0010, 32'h0,         2'b00, 1'b1, 32'hDEAD_55EF};
    vecs[9]  = '{1'b1, 32'h0000_0013, 32'h0000_1234, 2'b01, 1'b1, 32'h0000_0000};
    vecs[10] = '{1'b0, 32'h0000_0010, 32'h0,         2'b00, 1'b1, 32'hDEAD_55EF};
    vecs[11] = '{1'b1, 32'h0000_0014, 32'h1122_3344, 2'b00, 1'b0, 32'h0000_0000};
    vecs[12] = '{1'b1, 32'h0000_0016, 32'hFFFF_ABCD, 2'b01, 1'b1, 32'h0000_1122};
    vecs[13] = '{1'b0, 32'h0000_0014, 32'h0,         2'b00, 1'b1, 32'hABCD_3344};
    vecs[14] = '{1'b1, 32'h0000_0017, 32'h0000_0099, 2'b10, 1'b1, 32'h0000_00AB};
    vecs[15] = '{1'b0, 32'h0000_0014, 32'h0,         2'b11, 1'b1, 32'h99CD_3344};
    vecs[16] = '{1'b0, 32'h0000_0015, 32'h0,         2'b00, 1'b1, 32'h0000_0000};
    vecs[17] = '{1'b0, 32'h0000_1010, 32'h0,         2'b00, 1'b1, 32'hDEAD_55EF};
    vecs[18] = '{1'b0, 32'h0000_0017, 32'h0,         2'b01, 1'b1, 32'h0000_0000};
    vecs[19] = '{1'b0, 32'h0000_0016, 32'h0,         2'b01, 1'b1, 32'h0000_99CD};

    rst = 1'b1; MemWrite = 1'b0; addr = 32'h0; writedata = 32'h0; memOp = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check("reset_led", {16'h0, led}, 32'h0);
    check("reset_irq", {31'h0, irq}, 32'h0);
`ifdef DMEM_MMIO_EN
    addr = 32'h8000_0004; #1;
    check("reset_count_read", readdata, 32'h0);
    addr = 32'h8000_000C; #1;
    check("reset_status_read", readdata, 32'h0);
    addr = 32'h0;
`endif
    @(negedge clk);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 20; i++) begin
      cycle($sformatf("vec%0d", i), vecs[i].we, vecs[i].a, vecs[i].wd, vecs[i].op,
            vecs[i].chk, vecs[i].exp);
    end

`ifdef DMEM_MMIO_EN
    // Error flag and W1C.
    cycle("status_after_misalign", 1'b0, 32'h8000_000C, 32'h0, 2'b00, 1'b1, 32'h2);
    cycle("status_w1c_err", 1'b1, 32'h8000_000C, 32'h2, 2'b00, 1'b1, 32'h2);
    cycle("status_cleared", 1'b0, 32'h8000_000C, 32'h0, 2'b00, 1'b1, 32'h0);

    // LED register.
    cycle("led_write", 1'b1, 32'h8000_0000, 32'hFFFF_1234, 2'b00, 1'b0, 32'h0);
    check("led_after_write", {16'h0, led}, 32'h0000_1234);
    cycle("led_read", 1'b0, 32'h8000_0000, 32'h0, 2'b00, 1'b1, 32'h0000_1234);
    cycle("led_byte_write", 1'b1, 32'h8000_0000, 32'h0000_00FF, 2'b10, 1'b1, 32'h0);
    check("led_unchanged", {16'h0, led}, 32'h0000_1234);
    cycle("status_after_mmio_byte", 1'b0, 32'h8000_000C, 32'h0, 2'b00, 1'b1, 32'h2);
    cycle("led_alias_read", 1'b0, 32'h8ABC_DE00, 32'h0, 2'b00, 1'b1, 32'h0000_1234);
    cycle("status_clear_all", 1'b1, 32'h8000_000C, 32'h3, 2'b00, 1'b0, 32'h0);

    // Free-running COUNT with CMP=0; COUNT writes are ignored.
    cycle("cmp_zero_write", 1'b1, 32'h8000_0008, 32'h0, 2'b00, 1'b0, 32'h0);
    repeat (10) cycle("idle", 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 32'h0);
    cycle("count_after_10", 1'b1, 32'h8000_0004, 32'h5555, 2'b00, 1'b1, 32'd10);
    cycle("count_after_11", 1'b0, 32'h8000_0004, 32'h0, 2'b00, 1'b1, 32'd11);

    // Timer: CMP=4 written in cycle T, then cycles T+1..T+21.
    cycle("cmp4_write", 1'b1, 32'h8000_0008, 32'h4, 2'b00, 1'b0, 32'h0);
    for (int k = 1; k <= 21; k++) begin
      if (k == 7 || k == 15 || k == 16) begin
        apply("w1c_match", 1'b1, 32'h8000_000C, 32'h1, 2'b00, 1'b0, 32'h0);
      end else if (k == 20) begin
        apply("cmp_on_match", 1'b1, 32'h8000_0008, 32'h4, 2'b00, 1'b0, 32'h0);
      end else begin
        apply($sformatf("timer_count_k%0d", k), 1'b0, 32'h8000_0004, 32'h0, 2'b00,
              1'b1, exp_count(k));
      end
      settle();
      check($sformatf("timer_irq_k%0d", k), {31'h0, irq},
            {31'h0, ((k >= 6 && k <= 7) || (k >= 11 && k <= 16))});
      tick();
    end
    cycle("cmp_readback", 1'b0, 32'h8000_0008, 32'h0, 2'b00, 1'b1, 32'h4);

    // Asynchronous reset with LED set, CMP=3 and irq high.
    cycle("led_ffff", 1'b1, 32'h8000_0000, 32'h0000_FFFF, 2'b00, 1'b0, 32'h0);
    cycle("cmp3_write", 1'b1, 32'h8000_0008, 32'h3, 2'b00, 1'b0, 32'h0);
    begin
      int n;
      n = 0;
      while (irq !== 1'b1 && n < 20) begin
        cycle("wait_irq", 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 32'h0);
        n++;
      end
    end
    check("irq_before_reset", {31'h0, irq}, 32'h1);
    addr = 32'h8000_0000; memOp = 2'b00; #1;
    check("led_read_before_reset", readdata, 32'h0000_FFFF);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_led", {16'h0, led}, 32'h0);
    check("async_reset_irq", {31'h0, irq}, 32'h0);
    check("async_reset_led_read", readdata, 32'h0);
    addr = 32'h8000_000C; #1;
    check("async_reset_status_read", readdata, 32'h0);
`else
    // Without MMIO, addr[31] is ignored and led/irq stay low.
    cycle("high_addr_alias_read", 1'b0, 32'h8000_0010, 32'h0, 2'b00, 1'b1, 32'hDEAD_55EF);
    cycle("high_addr_write", 1'b1, 32'h8000_0020, 32'h1357_2468, 2'b00, 1'b0, 32'h0);
    cycle("high_addr_read_low", 1'b0, 32'h0000_0020, 32'h0, 2'b00, 1'b1, 32'h1357_2468);
    cycle("mmio_led_word_write", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 1'b0, 32'h0);
    check("led_tied_low", {16'h0, led}, 32'h0);
    check("irq_tied_low", {31'h0, irq}, 32'h0);
    #2;
    rst = 1'b1;
    #1;
`endif

    // A store pending while reset is held is dropped; RAM keeps its contents.
    MemWrite = 1'b1; addr = 32'h0000_0010; writedata = 32'h0BAD_F00D; memOp = 2'b00;
    @(posedge clk);
    #1;
    MemWrite = 1'b0; addr = 32'h0; writedata = 32'h0; memOp = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    tick();
    cycle("ram_kept_after_reset", 1'b0, 32'h0000_0010, 32'h0, 2'b00, 1'b1, 32'hDEAD_55EF);
`ifdef DMEM_MMIO_EN
    cycle("status_after_reset", 1'b0, 32'h8000_000C, 32'h0, 2'b00, 1'b1, 32'h0);
    cycle("cmp_after_reset", 1'b0, 32'h8000_0008, 32'h0, 2'b00, 1'b1, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
